// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder data memory: size defaults, FSM states, lane count.
package dm_pkg;

    localparam int DM_WORDS  = 3072;
    localparam int DM_ADDR_W = 12;
    localparam int DM_LANES  = 4;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dm_state_e;

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane merge: replaces the enabled bytes of an existing word with the store data.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wd,
    input  logic [3:0]  i_be,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < DM_LANES; i++) begin
            if (i_be[i]) begin
                o_merged[8*i +: 8] = i_wd[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Word-organised data memory for the MEM stage: lane-masked stores, combinational loads,
// self-clearing sweep after reset. Optional store trace enabled by defining DM_TRACE_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int WORDS  = DM_WORDS,
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteEn,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic [31:0] rd,
    output logic        busy,
    output logic        oor
);

    logic [31:0]       r_mem [WORDS];
    dm_state_e         r_state;
    dm_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;
    logic              w_ready;
    logic              w_we;
    logic              w_unused;

    assign w_idx   = addr[ADDR_W+1:2];
    assign oor     = (addr[31:ADDR_W+2] != '0) || (32'(w_idx) >= WORDS);
    assign w_ready = (r_state == DM_READY);
    assign w_we    = w_ready && !oor && (byteEn != 4'b0000);
    assign w_old   = r_mem[w_idx];
    assign rd      = (w_ready && !oor) ? w_old : 32'h0;
    assign busy    = (r_state == DM_CLEAR);

    dm_lane_merge u_merge (
        .i_old    (w_old),
        .i_wd     (wd),
        .i_be     (byteEn),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DM_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The sweep holds the counter at the last word once READY is reached.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            DM_CLEAR: begin
                if (r_cnt == ADDR_W'(WORDS - 1)) begin
                    w_state_nxt = DM_READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DM_READY: begin
                w_state_nxt = DM_READY;
            end
            default: begin
                w_state_nxt = DM_CLEAR;
            end
        endcase
    end

    // Array contents are not reset; the clear sweep zeroes them instead.
    always_ff @(posedge clk) begin
        if (r_state == DM_CLEAR) begin
            r_mem[r_cnt] <= 32'h0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_we) begin
            $display("%0t@%08h: *%08h <= %08h", $time, pc, {addr[31:2], 2'b00}, w_merged);
        end
    end
    assign w_unused = ^addr[1:0];
`else
    assign w_unused = ^{addr[1:0], pc};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder with a behavioural memory model and literal spot checks.
module tb_dm_responder;

    localparam int W = 3072;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byteEn = 4'hF;
    logic [31:0] wd = 32'hFFFF_FFFF;
    logic [31:0] pc = 32'h0;
    logic [31:0] rd;
    logic        busy;
    logic        oor;

    int n_checks = 0;
    int n_err = 0;

    dm_responder dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteEn (byteEn),
        .wd     (wd),
        .pc     (pc),
        .rd     (rd),
        .busy   (busy),
        .oor    (oor)
    );

    always #5 clk = ~clk;

    // Behavioural model: a word array, a busy flag and the clear position.
    logic [31:0] m_mem [W];
    bit          m_busy = 1'b1;
    int          m_cnt = 0;

    function automatic logic [31:0] exp_rd();
        if (m_busy || addr >= 4 * W) return 32'h0;
        return m_mem[addr >> 2];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge reset) begin
        m_busy = 1'b1;
        m_cnt  = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 32'h0;
            if (m_cnt == W - 1) m_busy = 1'b0;
            else m_cnt++;
        end else if (addr < 4 * W) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) m_mem[addr >> 2][8*b +: 8] = wd[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'h0, busy}, {31'h0, m_busy});
        chk("oor", {31'h0, oor}, {31'h0, addr >= 4 * W});
        chk("rd", rd, exp_rd());
    end

    task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] w, input logic [31:0] p);
        @(posedge clk);
        #1;
        reset  = r;
        addr   = a;
        byteEn = b;
        wd     = w;
        pc     = p;
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a;

        cyc(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0);
        cyc(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_rd", rd, 32'h0);

        n = 0;
        for (int k = 0; k < 4000; k++) begin
            cyc(1'b0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0);
            if (!busy) break;
            n++;
        end
        chk("clear_len", n, W);
        chk("word0_after_clear", rd, 32'h0);

        cyc(1'b0, 32'h10, 4'hF, 32'h1122_3344, 32'h0);
        cyc(1'b0, 32'h10, 4'b0010, 32'h0000_AA00, 32'h0);
        cyc(1'b0, 32'h10, 4'h0, 32'h0, 32'h0);
        chk("lane_merge", rd, 32'h1122_AA44);

        cyc(1'b0, 32'h20, 4'hF, 32'hDEAD_BEEF, 32'h0);
        chk("same_cycle_old", rd, 32'h0);
        cyc(1'b0, 32'h20, 4'h0, 32'h0, 32'h0);
        chk("same_cycle_new", rd, 32'hDEAD_BEEF);

        cyc(1'b0, 32'h3000, 4'hF, 32'hCAFE_F00D, 32'h0);
        chk("oor_idx_flag", {31'h0, oor}, 32'h1);
        chk("oor_idx_rd", rd, 32'h0);
        cyc(1'b0, 32'h4000, 4'hF, 32'hCAFE_F00D, 32'h0);
        chk("oor_hi_flag", {31'h0, oor}, 32'h1);
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("oor_no_alias", rd, 32'hFFFF_FFFF);
        cyc(1'b0, 32'h2FFF, 4'h0, 32'h0, 32'h0);
        chk("top_word_in_range", {31'h0, oor}, 32'h0);

        cyc(1'b0, 32'h4, 4'hF, 32'h1234_5678, 32'h0);
        cyc(1'b0, 32'h4, 4'b0001, 32'h0000_0055, 32'h0000_3008);
        cyc(1'b0, 32'h4, 4'h0, 32'h0, 32'h0);
        chk("trace_store", rd, 32'h1234_5655);

        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 9))
                0: a = $urandom;
                1: a = 32'h2F80 + $urandom_range(0, 255);
                default: a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            endcase
            cyc(1'b0, a, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        cyc(1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0);
        for (int k = 0; k < 100; k++) cyc(1'b0, 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0);
        chk("mid_clear_busy", {31'h0, busy}, 32'h1);
        cyc(1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0);
        n = 0;
        for (int k = 0; k < 4000; k++) begin
            cyc(1'b0, 32'h10, 4'h0, 32'h0, 32'h0);
            if (!busy) break;
            n++;
        end
        chk("reclear_len", n, W);
        for (int i = 0; i < W; i++) begin
            cyc(1'b0, 32'(i * 4), 4'h0, 32'h0, 32'h0);
            chk("sweep_zero", rd, 32'h0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
